// File: rtl/result_bcd_conv.sv
// Purpose: sequential binary-to-BCD converter (shift-and-add-3) for the calculator result path.
// Latency: 2*width clocks from the accepting start edge to done_o; one bit per clock.
// Backpressure: start_i is only sampled while idle; requests during a conversion are dropped.
module result_bcd_conv #(
    parameter int width  = 8,
    parameter int digits = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [2*width-1:0]    bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*digits-1:0]   bcd_o
);

    localparam int BW = 2 * width;
    localparam int DW = 4 * digits;
    localparam int CW = $clog2(BW + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic            done_q, done_d;

    logic [DW-1:0]   adj;
    logic [DW-1:0]   shifted;

    // Per-nibble add-3 correction followed by the one-bit left shift of the scratch.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < digits; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[DW-2:0], shift_q[BW-1]};
    end

    // Next-state logic: accept a request in IDLE, iterate in CONV, publish on the last bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d   = bin_i;
                    scratch_d = '0;
                    cnt_d     = CW'(BW);
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = shifted;
                shift_d   = {shift_q[BW-2:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Final iteration: the shifted scratch is the finished result.
                    bcd_d   = shifted;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    // Outputs come straight from flops: busy is the CONV state, never overlapping the done pulse.
    assign busy_o = (state_q == CONV);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_result_bcd_conv.sv
// Purpose: self-checking bench for result_bcd_conv with directed and random values.
// Latency: expects done_o exactly 2*width edges after the accepting edge.
// Backpressure: checks that starts during a conversion are ignored.
module tb_result_bcd_conv;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int LAT = 2 * W;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            start_i;
    logic [2*W-1:0]  bin_i;
    logic            busy_o;
    logic            done_o;
    logic [4*D-1:0]  bcd_o;

    int compared = 0;
    int mismatched = 0;

    result_bcd_conv #(.width(W), .digits(D)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: decimal digits by plain division, one nibble per digit.
    function automatic logic [4*D-1:0] ref_bcd(input int v);
        logic [4*D-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion from idle, called at a negedge; returns at a negedge with the DUT idle.
    task automatic do_conv(input logic [2*W-1:0] v, input string tag);
        logic [4*D-1:0] exp;
        logic [4*D-1:0] seen;
        int  done_at;
        bit  hs_ok;
        exp = ref_bcd(int'(v));
        seen = '0;
        done_at = -1;
        hs_ok = 1'b1;
        bin_i = v;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        if (!(busy_o === 1'b1 && done_o === 1'b0)) hs_ok = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                done_at = n;
                seen = bcd_o;
                if (busy_o !== 1'b0) hs_ok = 1'b0;
                break;
            end else if (n < LAT && busy_o !== 1'b1) begin
                hs_ok = 1'b0;
            end
        end
        @(negedge clk_i);
        if (done_o !== 1'b0 || busy_o !== 1'b0 || bcd_o !== exp) hs_ok = 1'b0;
        check({tag, "_latency"}, done_at, LAT);
        check({tag, "_bcd"}, seen, exp);
        check({tag, "_handshake"}, hs_ok, 1);
    endtask

    initial begin
        int  dcnt;
        int  dat;
        int  dat2;
        bit  ok;
        logic [2*W-1:0] rv;

        rst_ni = 1'b1;
        start_i = 1'b0;
        bin_i = '0;

        // Asynchronous reset mid-cycle; outputs clear without a clock edge.
        #13 rst_ni = 1'b0;
        #1;
        check("rst_bcd", bcd_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (bcd_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) ok = 1'b0;
        end
        check("idle_stable", ok, 1);

        // Directed values and extremes.
        do_conv(16'd0, "v0");
        do_conv(16'd9, "v9");
        do_conv(16'd10, "v10");
        do_conv(16'd255, "v255");
        do_conv(16'd65025, "v65025");
        do_conv(16'd65535, "v65535");
        do_conv(16'd39999, "v39999");

        // Start while busy: extra requests at cycles 3 and 10 must be ignored.
        bin_i = 16'd1234;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        dcnt = 0;
        dat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 3 || n == 10) begin
                start_i = 1'b1;
                bin_i = 16'd4321;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                dcnt++;
                if (dat < 0) dat = n;
            end
        end
        start_i = 1'b0;
        check("busy_start_done_count", dcnt, 1);
        check("busy_start_latency", dat, LAT);
        check("busy_start_bcd", bcd_o, 32'h01234);

        // Reset in the middle of a conversion discards it.
        bin_i = 16'd5000;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (7) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_bcd", bcd_o, 0);
        check("midrst_busy", busy_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o === 1'b1) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        check("midrst_bcd_hold", bcd_o, 0);
        do_conv(16'd77, "after_rst77");

        // Back-to-back with start held high: 100 then 200.
        bin_i = 16'd100;
        start_i = 1'b1;
        @(negedge clk_i);
        bin_i = 16'd200;
        dat = -1;
        dat2 = -1;
        ok = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk_i);
            if (n == LAT + 1) start_i = 1'b0;
            if (done_o === 1'b1) begin
                if (dat < 0) begin
                    dat = n;
                    if (bcd_o !== 20'h00100) ok = 1'b0;
                end else if (dat2 < 0) begin
                    dat2 = n;
                    if (bcd_o !== 20'h00200) ok = 1'b0;
                end
            end else if (dat > 0 && dat2 < 0 && bcd_o !== 20'h00100) begin
                ok = 1'b0;
            end
        end
        start_i = 1'b0;
        check("b2b_first_edge", dat, LAT);
        check("b2b_second_edge", dat2, 2 * LAT + 1);
        check("b2b_values_hold", ok, 1);
        check("b2b_final_bcd", bcd_o, 32'h00200);

        // Random values against the division-based model.
        for (int i = 0; i < 20; i++) begin
            rv = 16'($urandom_range(0, 65535));
            do_conv(rv, $sformatf("rand%0d_%0d", i, rv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/result_bcd_conv.md
# result_bcd_conv

Sequential binary-to-BCD converter for the calculator result path, using shift-and-add-3 (double dabble). It accepts the unsigned `2*width`-bit result word produced by the ALU and returns packed BCD digits for the display driver. It processes one input bit per clock and uses a start/busy/done handshake.

## Interface
Parameters:
- `width`, default 8: ALU operand width. The converted input is `2*width` bits.
- `digits`, default 5: number of BCD output digits.
  - Must satisfy `10**digits > 2**(2*width) - 1`.
  - The block does not check this at runtime.

Ports:
- `clk_i` (in, 1): single clock. All state updates on the rising edge.
- `rst_ni` (in, 1): reset. Asynchronous, active-low.
- `start_i` (in, 1): request a conversion of `bin_i`. Sampled only when `busy_o`=0.
- `bin_i` (in, `2*width`): unsigned binary value. Captured on the accepting edge.
- `busy_o` (out, 1): high while a conversion is in progress.
- `done_o` (out, 1): one-cycle pulse when `bcd_o` has been updated with a new result.
- `bcd_o` (out, `4*digits`): packed BCD, most-significant digit in the top nibble. Holds until the next `done_o`.

## Operation
- FSM states: IDLE, CONV.
- IDLE behaviour:
  - If `start_i`=1: load shift register with `bin_i`, clear the BCD scratch register to 0, load bit counter with `2*width`, go to CONV.
  - If `start_i`=0: stay in IDLE.
- CONV behaviour, one iteration per clock:
  - Adjust: every scratch nibble ≥5 gets +3. Nibbles are adjusted independently, 4-bit arithmetic, no carry between nibbles.
  - Shift: shift the adjusted scratch left by 1, filling the LSB with the MSB of the shift register. The shift register also shifts left by 1, zero-filled.
  - Decrement the counter.
- Completion, on the iteration where the counter is 1:
  - The shifted scratch value goes directly into `bcd_o`.
  - `done_o` is set, state returns to IDLE.
- `start_i` while in CONV is ignored: not queued, no effect on the current conversion.
- `bcd_o` changes only at completion and at reset.
- The input is unsigned only. Any sign/compare flag from the ALU bypasses this block.

## Timing
- Reset (`rst_ni`=0, any time, including mid-CONV):
  - state IDLE, counter 0, scratch 0.
  - `bcd_o`=0, `busy_o`=0, `done_o`=0.
  - The in-progress conversion is discarded. No `done_o` is produced after release.
- Let edge k be the edge where `start_i` is accepted:
  - `busy_o`=1 in the cycles after edges k … k+2w−1 (w = `width`).
  - Iterations occur at edges k+1 … k+2w.
  - At edge k+2w: `bcd_o` is valid, `done_o`=1 for exactly one cycle, `busy_o`=0.
- Latency from start edge to result: 2w edges (16 for w=8).
- Back-to-back operation:
  - `start_i` held high during the `done_o` cycle is accepted at edge k+2w+1.
  - Maximum throughput is one conversion per 2w+1 cycles.
  - `bcd_o` keeps the old result until the new conversion's `done_o`.
- `done_o` and `busy_o` are never high in the same cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset then idle: assert `rst_ni`=0 asynchronously mid-cycle → `bcd_o`=0x00000, `busy_o`=0, `done_o`=0 immediately. With `start_i`=0 the outputs stay constant.
- Basic values (w=8, digits=5), each `done_o` exactly 16 edges after start:
  - `bin_i`=0 → 0x00000.
  - `bin_i`=9 → 0x00009.
  - `bin_i`=10 → 0x00010.
  - `bin_i`=255 → 0x00255.
- Extremes:
  - `bin_i`=65025 (255×255, the maximum product) → 0x65025.
  - `bin_i`=65535 → 0x65535.
  - `bin_i`=39999 → 0x39999 (exercises the adjust on every nibble).
- Start while busy:
  - Start with 1234, then pulse `start_i` with 4321 at cycles 3 and 10 → single `done_o`, `bcd_o`=0x01234.
  - `done_o` count equals accepted starts.
- Reset mid-conversion:
  - Start 5000, drop `rst_ni` at cycle 8 for 2 cycles → `bcd_o`=0 and no `done_o`.
  - A new start of 77 then yields 0x00077 at the expected edge.
- Back-to-back: `start_i` held high with values 100 then 200 → `done_o` at edges k+16 and k+33, giving 0x00100 then 0x00200. `bcd_o` stays at 0x00100 between the two pulses.
